nios_system_sysid_checker: RTL
==============================

# nios_system_sysid_checker

Avalon-MM read master that sits directly downstream of the Qsys system-ID slave. It reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and presents registered pass/fail status plus the captured words. The check runs automatically after every reset and can be re-run on request. Software and the board LEDs use it to detect a mismatched .sof/.elf pairing.

## Interface
- EXPECTED_ID, 32'd0, expected word at address 0
- EXPECTED_TIMESTAMP, 32'd1480484887, expected word at address 1
- CHECK_TIMESTAMP, 1, 1 = compare timestamp; 0 = ts_ok forced to 1
- READ_LATENCY, 0, slave read latency in cycles; legal range 0..3
- clock  in  1  single clock; all logic on the rising edge
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to re-run the check
- sysid_address  out  1  slave word address
- sysid_read  out  1  read strobe, one cycle per access
- sysid_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  check complete; held until the next check starts
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP, or 1 if CHECK_TIMESTAMP=0
- pass  out  1  id_ok & ts_ok
- id_value  out  32  captured ID word
- timestamp_value  out  32  captured timestamp word
- fail_count  out  8  count of completed checks with pass=0; saturates at 255

## Operation
- States: IDLE, ISSUE_ID, WAIT_ID, ISSUE_TS, WAIT_TS, DONE. IDLE is entered only through reset.
- IDLE: unconditional transition to ISSUE_ID on the next edge, giving an automatic check after reset.
- ISSUE_ID: sysid_read=1, sysid_address=0, for one cycle.
  - READ_LATENCY=0: capture sysid_readdata into id_value at the end of this cycle, then go to ISSUE_TS.
  - Otherwise go to WAIT_ID.
- WAIT_ID: sysid_read=0, sysid_address held at 0. A 2-bit latency counter runs 1..READ_LATENCY. When the counter equals READ_LATENCY, capture id_value and go to ISSUE_TS.
- ISSUE_TS / WAIT_TS: identical to the ID states, with sysid_address=1 and capture into timestamp_value. The final capture goes to DONE.
- On the DONE entry edge:
  - id_ok, ts_ok and pass are registered from the captured values.
  - done is set.
  - fail_count increments if pass would be 0, unless it is already 255.
- DONE: waits for start. When start=1, on the next edge done, id_ok, ts_ok and pass clear and the FSM goes to ISSUE_ID. id_value and timestamp_value keep their old contents until they are overwritten.
- busy=1 in ISSUE_ID, WAIT_ID, ISSUE_TS, WAIT_TS and IDLE; otherwise 0.
- sysid_address=1 in ISSUE_TS and WAIT_TS; otherwise 0.
- start outside DONE is ignored; it is not queued.
- All comparisons are full 32-bit equality.

## Timing
- Reset values, in force while reset_n=0 at an edge: state=IDLE, sysid_read=0, sysid_address=0, done=0, id_ok=0, ts_ok=0, pass=0, id_value=0, timestamp_value=0, fail_count=0, latency counter=0. busy reads 1 (state IDLE).
- Reset asserted mid-check (any state): the same reset values apply, the partial check is discarded, and the check reruns automatically after release.
- Cycle numbering: cycle 0 is the first cycle with reset_n=1.
  - Cycle 0 is IDLE.
  - ID read strobe in cycle 1.
  - Timestamp read strobe in cycle 2+READ_LATENCY.
  - done=1 from cycle 3+2·READ_LATENCY.
- A check started by start in cycle n gives done=0 in cycle n+1, read strobes in cycles n+1 and n+2+READ_LATENCY, and done=1 from cycle n+3+2·READ_LATENCY.
- sysid_readdata is sampled only on the capture edges defined above; it is don't-care in every other cycle.

## Test plan
- READ_LATENCY=0; slave model returns 0 / 1480484887. Release reset -> sysid_read in cycles 1 (addr 0) and 2 (addr 1); done=pass=1 in cycle 3; fail_count=0.
- Slave returns 32'h1 at address 0 -> id_ok=0, ts_ok=1, pass=0, fail_count=1. Then pulse start in DONE -> done drops the next cycle, the check reruns, and fail_count=2.
- READ_LATENCY=2; model drives 32'hDEADBEEF except exactly 2 cycles after each strobe -> strobes in cycles 1 and 4 only, address stable during the waits, done in cycle 7, pass=1.
- CHECK_TIMESTAMP=0 with a wrong timestamp -> ts_ok=1, pass=1, and timestamp_value shows the wrong word.
- start pulsed in WAIT_ID is ignored (exactly one DONE entry). Reset during WAIT_TS -> all outputs at their reset values the next cycle, fail_count=0, and the check reruns.
- Force 260 failing checks via start -> fail_count stops at 255 and does not wrap.

Source files
------------

// File: rtl/nios_system_sysid_checker_if.sv
// nios_system_sysid_checker_if: Avalon-MM read channel between the checker (master) and the sysid slave
interface nios_system_sysid_checker_if;
  logic        sysid_address;
  logic        sysid_read;
  logic [31:0] sysid_readdata;
  modport master(output sysid_address, output sysid_read, input sysid_readdata);
  modport slave(input sysid_address, input sysid_read, output sysid_readdata);
endinterface

// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker: reads the sysid ID/timestamp words and checks them against build-time values
// Ports: clock, reset_n (synchronous, active-low); start re-runs the check from DONE;
// bus is the Avalon-MM read master towards the sysid slave; busy/done/id_ok/ts_ok/pass,
// id_value/timestamp_value and the saturating fail_count are registered status.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480484887,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int          READ_LATENCY       = 0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  nios_system_sysid_checker_if.master         bus,
  output logic                                busy,
  output logic                                done,
  output logic                                id_ok,
  output logic                                ts_ok,
  output logic                                pass,
  output logic [31:0]                         id_value,
  output logic [31:0]                         timestamp_value,
  output logic [7:0]                          fail_count
);
  typedef enum logic [2:0] {IDLE, ISSUE_ID, WAIT_ID, ISSUE_TS, WAIT_TS, DONE} state_t;
  localparam logic [1:0] LAT = 2'(READ_LATENCY);
  state_t      state_q, state_d;
  logic [1:0]  lat_q, lat_d;
  logic        done_q, done_d, id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, pass_q, pass_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic [7:0]  fail_q, fail_d;
  logic        fin, id_match, ts_match;
  // The timestamp is compared straight off the bus because it lands on the same edge DONE is entered.
  assign id_match = id_q == EXPECTED_ID;
  assign ts_match = !CHECK_TIMESTAMP || bus.sysid_readdata == EXPECTED_TIMESTAMP;
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    done_d  = done_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    pass_d  = pass_q;
    id_d    = id_q;
    ts_d    = ts_q;
    fail_d  = fail_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: state_d = ISSUE_ID;
      ISSUE_ID, WAIT_ID:
        if (LAT == 2'd0 || (state_q == WAIT_ID && lat_q == LAT)) begin
          id_d    = bus.sysid_readdata;
          lat_d   = 2'd0;
          state_d = ISSUE_TS;
        end else begin
          lat_d   = lat_q + 2'd1;
          state_d = WAIT_ID;
        end
      ISSUE_TS, WAIT_TS:
        if (LAT == 2'd0 || (state_q == WAIT_TS && lat_q == LAT)) fin = 1'b1;
        else begin
          lat_d   = lat_q + 2'd1;
          state_d = WAIT_TS;
        end
      DONE:
        if (start) begin
          state_d = ISSUE_ID;
          done_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          pass_d  = 1'b0;
        end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      ts_d    = bus.sysid_readdata;
      lat_d   = 2'd0;
      state_d = DONE;
      done_d  = 1'b1;
      id_ok_d = id_match;
      ts_ok_d = ts_match;
      pass_d  = id_match && ts_match;
      fail_d  = (!(id_match && ts_match) && fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= 2'd0;
      done_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      pass_q  <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      fail_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      pass_q  <= pass_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      fail_q  <= fail_d;
    end
  end
  assign bus.sysid_read    = state_q == ISSUE_ID || state_q == ISSUE_TS;
  assign bus.sysid_address = state_q == ISSUE_TS || state_q == WAIT_TS;
  assign busy              = state_q != DONE;
  assign done              = done_q;
  assign id_ok             = id_ok_q;
  assign ts_ok             = ts_ok_q;
  assign pass              = pass_q;
  assign id_value          = id_q;
  assign timestamp_value   = ts_q;
  assign fail_count        = fail_q;
endmodule
